mem_arb: RTL and testbench

Two-master arbiter that shares the core's single external memory port between the instruction-cache refill path and the data-cache path (line refills and write-through stores). It sits between the two cache controllers and the memory bus. It serialises their transactions with round-robin arbitration and sequences multi-beat line fills with a beat counter. While the cache controllers wait for `*_done`, they hold the hazard-control stall inputs asserted.

---
 rtl/mem_arb.sv | 104 ++++++++++
 tb/tb_mem_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port between the I-cache refill
// path and the D-cache path, sequencing line fills with a beat counter.
module mem_arb #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_BEATS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_ack,
   input  logic [DATA_W-1:0]   m_rdata
);
   localparam int BW   = $clog2(LINE_BEATS);
   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic              last_d_q, last_d_d;
   logic [ADDR_W-1:2] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic              gnt_d, rd, wr, last_beat, unused;

   // D wins unless I is also requesting and D was the previous owner
   assign gnt_d     = d_req && (!i_req || !last_d_q);
   assign rd        = state_q == I_RD || state_q == D_RD;
   assign wr        = state_q == D_WR;
   assign last_beat = beat_q == BW'(LINE_BEATS - 1);
   assign unused    = ^{i_addr[1:0], d_addr[1:0]};

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      if (state_q == IDLE) begin
         if (i_req || d_req) begin
            state_d  = !gnt_d ? I_RD : d_we ? D_WR : D_RD;
            beat_d   = '0;
            last_d_d = gnt_d;
            addr_d   = gnt_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
            wdata_d  = d_wdata;
            be_d     = d_be;
         end
      end else if (m_ack) begin
         beat_d  = rd ? beat_q + 1'b1 : beat_q;
         state_d = (wr || last_beat) ? IDLE : state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
      end
   end

   // line fills walk the aligned line in order; stores keep the word address
   assign m_req   = state_q != IDLE;
   assign m_we    = wr;
   assign m_addr  = rd ? {addr_q[ADDR_W-1:BW+2], beat_q, 2'b00} : wr ? {addr_q, 2'b00} : '0;
   assign m_wdata = wr ? wdata_q : '0;
   assign m_be    = rd ? '1 : wr ? be_q : '0;

   assign i_rvalid = state_q == I_RD && m_ack;
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign i_done   = i_rvalid && last_beat;
   assign d_rvalid = state_q == D_RD && m_ack;
   assign d_rdata  = d_rvalid ? m_rdata : '0;
   assign d_done   = (d_rvalid && last_beat) || (wr && m_ack);
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: randomized self-checking bench for mem_arb against a
// transaction-level model of round-robin grants and line-fill address streams.
module tb_mem_arb;
   localparam int AW = 32, DW = 32, LB = 4;

   typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} djob_t;
   typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int cyc;} beat_t;

   logic clk = 0, rst_n = 0;
   logic i_req, i_rvalid, i_done, d_req, d_we, d_rvalid, d_done, m_req, m_we, m_ack;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic [3:0] d_be, m_be;

   mem_arb #(.ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // memory responder: per-beat wait counts from gaps, else 0 or random
   int gaps[$];
   bit rand_gap = 0, spur = 0;
   initial begin
      int cnt, need;
      cnt = 0; need = -1; m_ack = 0; m_rdata = 0;
      forever begin
         @(posedge clk); #1;
         if (spur) begin
            m_ack = 1; m_rdata = $urandom;
         end else if (m_req) begin
            if (need < 0) need = gaps.size() > 0 ? gaps.pop_front() : rand_gap ? int'($urandom_range(0, 2)) : 0;
            if (cnt >= need) begin
               m_ack = 1; m_rdata = mem_word(m_addr); cnt = 0; need = -1;
            end else begin
               m_ack = 0; m_rdata = $urandom; cnt++;
            end
         end else begin
            m_ack = 0; m_rdata = $urandom; cnt = 0; need = -1;
         end
      end
   end

   // monitor
   beat_t mb[$];
   logic [31:0] iw[$], dw[$];
   int done_who[$], done_cyc[$], done_nw[$];
   int stab_err = 0, zero_err = 0, req_cycles = 0;
   initial begin
      logic p_req, p_ack, p_we;
      logic [31:0] p_addr;
      p_req = 0; p_ack = 0; p_we = 0; p_addr = 0;
      forever begin
         @(negedge clk);
         if (m_req && m_ack) mb.push_back('{m_addr, m_we, m_be, m_wdata, cyc});
         if (i_rvalid) iw.push_back(i_rdata);
         if (d_rvalid) dw.push_back(d_rdata);
         if (i_done) begin done_who.push_back(0); done_cyc.push_back(cyc); done_nw.push_back(iw.size()); end
         if (d_done) begin done_who.push_back(1); done_cyc.push_back(cyc); done_nw.push_back(dw.size()); end
         if (m_req) req_cycles++;
         if (m_req && p_req && !p_ack && (m_addr !== p_addr || m_we !== p_we)) stab_err++;
         if ((!i_rvalid && (i_rdata !== 0 || i_done)) || (!d_rvalid && d_rdata !== 0) ||
             (!m_req && (m_we || m_addr !== 0 || m_wdata !== 0 || m_be !== 0))) zero_err++;
         p_req = m_req; p_ack = m_ack; p_we = m_we; p_addr = m_addr;
      end
   end

   // requester agents: hold req across back-to-back jobs, drop it when the queue empties
   logic [31:0] ij[$];
   djob_t dj[$];
   int i_start[$], d_start[$];
   initial begin
      i_req = 0; i_addr = 0;
      forever begin
         @(negedge clk);
         if (i_req && i_done) void'(ij.pop_front());
         if (ij.size() > 0) begin
            if (!i_req) i_start.push_back(cyc);
            i_req = 1; i_addr = ij[0];
         end else i_req = 0;
      end
   end
   initial begin
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      forever begin
         @(negedge clk);
         if (d_req && d_done) void'(dj.pop_front());
         if (dj.size() > 0) begin
            if (!d_req) d_start.push_back(cyc);
            d_req = 1; d_we = dj[0].we; d_addr = dj[0].addr; d_wdata = dj[0].wdata; d_be = dj[0].be;
         end else d_req = 0;
      end
   end

   // reference model: whole-transaction grant order and expected beat stream
   bit mdl_last_d = 0;
   logic [31:0] mi[$];
   djob_t md[$];
   beat_t exp_beats[$];
   int exp_who[$];
   logic [31:0] exp_iw[$], exp_dw[$];
   function automatic void model_run();
      djob_t j;
      logic [31:0] a, base;
      bit take_d;
      while (mi.size() > 0 || md.size() > 0) begin
         take_d = md.size() > 0 && (mi.size() == 0 || !mdl_last_d);
         mdl_last_d = take_d;
         exp_who.push_back(int'(take_d));
         if (take_d) begin
            j = md.pop_front();
            if (j.we) exp_beats.push_back('{j.addr & 32'hFFFF_FFFC, 1'b1, j.be, j.wdata, 0});
            base = j.addr & ~32'(LB * 4 - 1);
         end else base = mi.pop_front() & ~32'(LB * 4 - 1);
         if (!take_d || !j.we)
            for (int k = 0; k < LB; k++) begin
               a = base + 32'(4 * k);
               exp_beats.push_back('{a, 1'b0, 4'hF, 32'h0, 0});
               if (take_d) exp_dw.push_back(mem_word(a)); else exp_iw.push_back(mem_word(a));
            end
      end
   endfunction

   task automatic clr();
      mb.delete(); iw.delete(); dw.delete(); done_who.delete(); done_cyc.delete(); done_nw.delete();
      i_start.delete(); d_start.delete(); exp_beats.delete(); exp_who.delete(); exp_iw.delete(); exp_dw.delete();
      stab_err = 0; zero_err = 0; req_cycles = 0;
   endtask

   task automatic wait_done(input int n, input int budget, input string nm);
      int k = 0;
      while (done_who.size() < n && k < budget) begin @(negedge clk); #1; k++; end
      n_chk++;
      if (done_who.size() < n) begin n_fail++; $display("FAIL %s done count: got %0d want %0d", nm, done_who.size(), n); end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if ({m_req, m_we, m_addr, m_wdata, m_be, i_rvalid, i_rdata, i_done, d_rvalid, d_rdata, d_done} !== '0) begin
         n_fail++; $display("FAIL reset outputs: m_req=%b m_addr=%h m_be=%h i_rv=%b d_rv=%b want all 0", m_req, m_addr, m_be, i_rvalid, d_rvalid);
      end
      rst_n = 1; mdl_last_d = 0;
      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (m_req !== 1'b0) begin n_fail++; $display("FAIL idle m_req: got %b want 0", m_req); end
   endtask

   task automatic test_i_refill();
      clr();
      mi.push_back(32'h104C); model_run();
      ij.push_back(32'h104C);
      wait_done(1, 50, "i_refill");
      n_chk++;
      if (m_req !== 1'b0) begin n_fail++; $display("FAIL i_refill m_req after done: got %b want 0", m_req); end
      n_chk++;
      if (mb.size() != 4 || iw.size() != 4) begin n_fail++; $display("FAIL i_refill beats: got %0d/%0d want 4/4", mb.size(), iw.size()); end
      for (int k = 0; k < 4 && k < mb.size() && k < iw.size(); k++) begin
         n_chk++;
         if ({mb[k].addr, mb[k].we, mb[k].be, iw[k]} !== {32'h1040 + 32'(4 * k), 1'b0, 4'hF, mem_word(32'h1040 + 32'(4 * k))}) begin
            n_fail++; $display("FAIL i_refill beat%0d: addr=%h we=%b be=%h data=%h want addr=%h", k, mb[k].addr, mb[k].we, mb[k].be, iw[k], 32'h1040 + 32'(4 * k));
         end
      end
      if (done_who.size() > 0 && i_start.size() > 0 && mb.size() > 0) begin
         n_chk++;
         if ({done_who[0], done_nw[0], done_cyc[0] - i_start[0], mb[0].cyc - i_start[0]} !== {32'd0, 32'd4, 32'(LB), 32'd1}) begin
            n_fail++; $display("FAIL i_refill timing: who=%0d nwords=%0d occ=%0d lat=%0d want 0 4 %0d 1", done_who[0], done_nw[0], done_cyc[0] - i_start[0], mb[0].cyc - i_start[0], LB);
         end
      end
      n_chk++;
      if (zero_err != 0) begin n_fail++; $display("FAIL i_refill idle-zero violations: got %0d want 0", zero_err); end
   endtask

   task automatic test_tie();
      djob_t j;
      rst_n = 0; @(negedge clk); #1; rst_n = 1; mdl_last_d = 0;
      for (int r = 1; r <= 2; r++) begin
         clr();
         for (int k = 0; k < r; k++) begin
            j = '{1'b0, $urandom, 32'h0, 4'h0};
            md.push_back(j); dj.push_back(j);
            mi.push_back($urandom); ij.push_back(mi[mi.size() - 1]);
         end
         model_run();
         wait_done(2 * r, 40 * r, "tie");
         n_chk++;
         if (done_who.size() != exp_who.size() || mb.size() != exp_beats.size()) begin
            n_fail++; $display("FAIL tie round%0d counts: dones=%0d beats=%0d want %0d %0d", r, done_who.size(), mb.size(), exp_who.size(), exp_beats.size());
         end
         for (int k = 0; k < exp_who.size() && k < done_who.size(); k++) begin
            n_chk++;
            if (done_who[k] !== exp_who[k]) begin n_fail++; $display("FAIL tie round%0d order[%0d]: got %0d want %0d", r, k, done_who[k], exp_who[k]); end
         end
         for (int k = 0; k < exp_beats.size() && k < mb.size(); k++) begin
            n_chk++;
            if ({mb[k].addr, mb[k].we, mb[k].be} !== {exp_beats[k].addr, exp_beats[k].we, exp_beats[k].be}) begin
               n_fail++; $display("FAIL tie round%0d beat%0d: addr=%h we=%b be=%h want %h %b %h", r, k, mb[k].addr, mb[k].we, mb[k].be, exp_beats[k].addr, exp_beats[k].we, exp_beats[k].be);
            end
         end
         n_chk++;
         if (iw.size() != exp_iw.size() || dw.size() != exp_dw.size()) begin n_fail++; $display("FAIL tie round%0d words: got %0d/%0d want %0d/%0d", r, iw.size(), dw.size(), exp_iw.size(), exp_dw.size()); end
         else for (int k = 0; k < iw.size(); k++) if (iw[k] !== exp_iw[k] || dw[k] !== exp_dw[k]) begin
            n_fail++; $display("FAIL tie round%0d word%0d: i=%h d=%h want %h %h", r, k, iw[k], dw[k], exp_iw[k], exp_dw[k]); break;
         end
      end
   endtask

   task automatic test_d_write();
      clr();
      gaps.push_back(3);
      md.push_back('{1'b1, 32'h2003, 32'hAABBCCDD, 4'b0100}); model_run();
      dj.push_back('{1'b1, 32'h2003, 32'hAABBCCDD, 4'b0100});
      wait_done(1, 50, "d_write");
      n_chk++;
      if (mb.size() != 1) begin n_fail++; $display("FAIL d_write beats: got %0d want 1", mb.size()); end
      else if ({mb[0].addr, mb[0].we, mb[0].be, mb[0].wdata} !== {32'h2000, 1'b1, 4'b0100, 32'hAABBCCDD}) begin
         n_fail++; $display("FAIL d_write bus: addr=%h we=%b be=%h wdata=%h want 2000 1 4 aabbccdd", mb[0].addr, mb[0].we, mb[0].be, mb[0].wdata);
      end
      n_chk++;
      if (req_cycles != 4 || stab_err != 0) begin n_fail++; $display("FAIL d_write hold: req_cycles=%0d unstable=%0d want 4 0", req_cycles, stab_err); end
      n_chk++;
      if (dw.size() != 0) begin n_fail++; $display("FAIL d_write rvalid pulses: got %0d want 0", dw.size()); end
      if (done_who.size() > 0 && d_start.size() > 0) begin
         n_chk++;
         if (done_who[0] !== 1 || done_cyc[0] - d_start[0] != 4) begin
            n_fail++; $display("FAIL d_write done: who=%0d occ=%0d want 1 4", done_who[0], done_cyc[0] - d_start[0]);
         end
      end
   endtask

   task automatic test_wait_states();
      int g[4] = '{0, 2, 0, 5};
      int prev;
      logic [31:0] a;
      clr();
      a = $urandom;
      foreach (g[k]) gaps.push_back(g[k]);
      mi.push_back(a); model_run();
      ij.push_back(a);
      wait_done(1, 80, "wait_states");
      n_chk++;
      if (mb.size() != 4 || iw.size() != 4 || stab_err != 0) begin
         n_fail++; $display("FAIL wait_states: beats=%0d words=%0d unstable=%0d want 4 4 0", mb.size(), iw.size(), stab_err);
      end
      prev = i_start.size() > 0 ? i_start[0] : 0;
      for (int k = 0; k < 4 && k < mb.size(); k++) begin
         n_chk++;
         if (mb[k].addr !== (a & ~32'(LB * 4 - 1)) + 32'(4 * k) || mb[k].cyc - prev != g[k] + 1) begin
            n_fail++; $display("FAIL wait_states beat%0d: addr=%h spacing=%0d want %h %0d", k, mb[k].addr, mb[k].cyc - prev, (a & ~32'(LB * 4 - 1)) + 32'(4 * k), g[k] + 1);
         end
         prev = mb[k].cyc;
      end
      if (done_cyc.size() > 0 && mb.size() == 4) begin
         n_chk++;
         if (done_cyc[0] != mb[3].cyc) begin n_fail++; $display("FAIL wait_states done cycle: got %0d want %0d", done_cyc[0], mb[3].cyc); end
      end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      djob_t j;
      clr();
      dj.push_back('{1'b0, $urandom, 32'h0, 4'h0});
      while (dw.size() < 2 && k < 40) begin @(negedge clk); #1; k++; end
      n_chk++;
      if (dw.size() != 2) begin n_fail++; $display("FAIL reset_mid beats before reset: got %0d want 2", dw.size()); end
      dj.delete(); d_req = 0; rst_n = 0;
      @(negedge clk); #1;
      n_chk++;
      if (m_req !== 1'b0 || done_who.size() != 0 || dw.size() != 2) begin
         n_fail++; $display("FAIL reset_mid abort: m_req=%b dones=%0d words=%0d want 0 0 2", m_req, done_who.size(), dw.size());
      end
      rst_n = 1; mdl_last_d = 0;
      clr();
      j = '{1'b0, $urandom, 32'h0, 4'h0};
      md.push_back(j); dj.push_back(j);
      mi.push_back($urandom); ij.push_back(mi[0]);
      model_run();
      wait_done(2, 60, "reset_mid");
      n_chk++;
      if (done_who.size() < 1 || mb.size() != 2 * LB || done_who[0] !== exp_who[0] || mb[0].addr !== exp_beats[0].addr) begin
         n_fail++; $display("FAIL reset_mid restart: first=%0d addr=%h beats=%0d want %0d %h %0d", done_who.size() > 0 ? done_who[0] : -1, mb.size() > 0 ? mb[0].addr : 0, mb.size(), exp_who[0], exp_beats[0].addr, 2 * LB);
      end
   endtask

   task automatic test_spurious();
      clr();
      spur = 1;
      repeat (3) @(negedge clk);
      #1; spur = 0;
      @(negedge clk); #1;
      n_chk++;
      if (iw.size() + dw.size() + done_who.size() + req_cycles != 0) begin
         n_fail++; $display("FAIL spurious ack: words=%0d dones=%0d req_cycles=%0d want 0", iw.size() + dw.size(), done_who.size(), req_cycles);
      end
      mi.push_back($urandom); ij.push_back(mi[0]);
      md.push_back('{1'b0, $urandom, 32'h0, 4'h0}); dj.push_back(md[0]);
      model_run();
      wait_done(2, 60, "spurious");
      n_chk++;
      if (done_who.size() < 1 || mb.size() < 1 || done_who[0] !== exp_who[0] || mb[0].addr !== exp_beats[0].addr) begin
         n_fail++; $display("FAIL spurious after: first=%0d addr=%h want %0d %h", done_who.size() > 0 ? done_who[0] : -1, mb.size() > 0 ? mb[0].addr : 0, exp_who[0], exp_beats[0].addr);
      end
   endtask

   task automatic test_random();
      int ci, cd;
      djob_t j;
      rand_gap = 1;
      for (int r = 0; r < 8; r++) begin
         clr();
         ci = $urandom_range(0, 2); cd = $urandom_range(0, 2);
         if (ci + cd == 0) ci = 1;
         for (int k = 0; k < ci; k++) begin mi.push_back($urandom); ij.push_back(mi[mi.size() - 1]); end
         for (int k = 0; k < cd; k++) begin
            j = '{1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom)};
            md.push_back(j); dj.push_back(j);
         end
         model_run();
         wait_done(ci + cd, 200, "random");
         n_chk++;
         if (done_who.size() != exp_who.size() || mb.size() != exp_beats.size() || iw.size() != exp_iw.size() || dw.size() != exp_dw.size()) begin
            n_fail++; $display("FAIL random round%0d counts: dones=%0d beats=%0d want %0d %0d", r, done_who.size(), mb.size(), exp_who.size(), exp_beats.size());
         end else begin
            foreach (exp_who[k]) if (done_who[k] !== exp_who[k]) begin
               n_fail++; $display("FAIL random round%0d order[%0d]: got %0d want %0d", r, k, done_who[k], exp_who[k]); break;
            end
            n_chk++;
            foreach (exp_beats[k]) if ({mb[k].addr, mb[k].we, mb[k].be, mb[k].we ? mb[k].wdata : 32'h0} !==
                                       {exp_beats[k].addr, exp_beats[k].we, exp_beats[k].be, exp_beats[k].wdata}) begin
               n_fail++; $display("FAIL random round%0d beat%0d: addr=%h we=%b be=%h wd=%h want %h %b %h %h", r, k, mb[k].addr, mb[k].we, mb[k].be, mb[k].wdata, exp_beats[k].addr, exp_beats[k].we, exp_beats[k].be, exp_beats[k].wdata); break;
            end
            n_chk++;
            foreach (exp_iw[k]) if (iw[k] !== exp_iw[k]) begin n_fail++; $display("FAIL random round%0d iword%0d: got %h want %h", r, k, iw[k], exp_iw[k]); break; end
            foreach (exp_dw[k]) if (dw[k] !== exp_dw[k]) begin n_fail++; $display("FAIL random round%0d dword%0d: got %h want %h", r, k, dw[k], exp_dw[k]); break; end
         end
         n_chk++;
         if (stab_err != 0 || zero_err != 0) begin n_fail++; $display("FAIL random round%0d protocol: unstable=%0d idle-nonzero=%0d want 0 0", r, stab_err, zero_err); end
      end
      rand_gap = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_i_refill();
      test_tie();
      test_d_write();
      test_wait_states();
      test_reset_mid();
      test_spurious();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
